// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: condition-code values, flag bit
// positions, predication states and the condition evaluation function.
package cond_pkg;

   localparam logic [3:0] CC_EQ = 4'd0;
   localparam logic [3:0] CC_NE = 4'd1;
   localparam logic [3:0] CC_CS = 4'd2;
   localparam logic [3:0] CC_CC = 4'd3;
   localparam logic [3:0] CC_MI = 4'd4;
   localparam logic [3:0] CC_PL = 4'd5;
   localparam logic [3:0] CC_VS = 4'd6;
   localparam logic [3:0] CC_VC = 4'd7;
   localparam logic [3:0] CC_HI = 4'd8;
   localparam logic [3:0] CC_LS = 4'd9;
   localparam logic [3:0] CC_GE = 4'd10;
   localparam logic [3:0] CC_LT = 4'd11;
   localparam logic [3:0] CC_GT = 4'd12;
   localparam logic [3:0] CC_LE = 4'd13;
   localparam logic [3:0] CC_AL = 4'd14;
   localparam logic [3:0] CC_NV = 4'd15;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pred_state_e;

   function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] flags);
      logic n;
      logic z;
      logic c;
      logic v;
      logic res;
      n = flags[FLG_N];
      z = flags[FLG_Z];
      c = flags[FLG_C];
      v = flags[FLG_V];
      case (cc)
         CC_EQ:   res = z;
         CC_NE:   res = !z;
         CC_CS:   res = c;
         CC_CC:   res = !c;
         CC_MI:   res = n;
         CC_PL:   res = !n;
         CC_VS:   res = v;
         CC_VC:   res = !v;
         CC_HI:   res = c & !z;
         CC_LS:   res = !c | z;
         CC_GE:   res = (n == v);
         CC_LT:   res = (n != v);
         CC_GT:   res = !z & (n == v);
         CC_LE:   res = z | (n != v);
         CC_AL:   res = 1'b1;
         CC_NV:   res = 1'b0;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Bundle of flag, query and predication signals between the ALU/issue logic
// (master) and the condition unit (slave).
interface cond_unit_if #(
   parameter int NUM_CH = 2,
   parameter int LEN_W  = 3
);
   logic [3:0]          flag_in;
   logic                flag_we;
   logic [3:0]          flag_mask;
   logic [NUM_CH-1:0]   q_valid;
   logic [4*NUM_CH-1:0] q_cc;
   logic [NUM_CH-1:0]   r_valid;
   logic [NUM_CH-1:0]   r_cond;
   logic                pred_start;
   logic [3:0]          pred_cc;
   logic [LEN_W-1:0]    pred_len;
   logic                instr_adv;
   logic                pred_active;
   logic                exec_ok;
   logic                pred_err;
   logic [3:0]          flags;

   modport master (
      output flag_in, flag_we, flag_mask, q_valid, q_cc,
             pred_start, pred_cc, pred_len, instr_adv,
      input  r_valid, r_cond, pred_active, exec_ok, pred_err, flags
   );

   modport slave (
      input  flag_in, flag_we, flag_mask, q_valid, q_cc,
             pred_start, pred_cc, pred_len, instr_adv,
      output r_valid, r_cond, pred_active, exec_ok, pred_err, flags
   );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition evaluator: one condition code against one flag set.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cc,
   input  logic [3:0] flags,
   output logic       res
);

   always_comb begin
      res = cond_pkg::cond_eval(cc, flags);
   end

endmodule

// File: rtl/cond_unit.sv
// NZCV flag register with NUM_CH registered condition-query channels and an
// IT-style predicated-block state machine gating the issue slot.
module cond_unit
   import cond_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int MAX_LEN = 4,
   parameter int BYPASS  = 1,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic      clk,
   input  logic      rst,
   cond_unit_if.slave bus
);

   localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(0);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic [3:0]        flags_q, flags_d;
   logic [3:0]        eval_flags_s;
   logic [NUM_CH-1:0] r_valid_q, r_valid_d;
   logic [NUM_CH-1:0] r_cond_q, r_cond_d;
   logic [NUM_CH-1:0] ch_res_s;
   pred_state_e       state_q, state_d;
   logic [3:0]        pcc_q, pcc_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              pred_err_q, pred_err_d;
   logic              fsm_res_s;
   logic              start_ok_s;
   logic              last_adv_s;
   logic [LEN_W-1:0]  len_clamp_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      cond_eval u_ch (
         .cc    (bus.q_cc[4*i +: 4]),
         .flags (eval_flags_s),
         .res   (ch_res_s[i])
      );
   end

   cond_eval u_fsm_eval (
      .cc    (pcc_q),
      .flags (eval_flags_s),
      .res   (fsm_res_s)
   );

   // Flag merge, bypass selection and query result capture.
   always_comb begin
      flags_d = flags_q;
      if (bus.flag_we) begin
         flags_d = (flags_q & ~bus.flag_mask) | (bus.flag_in & bus.flag_mask);
      end else begin
         flags_d = flags_q;
      end
      if (BYPASS != 0) begin
         eval_flags_s = flags_d;
      end else begin
         eval_flags_s = flags_q;
      end
      r_valid_d = bus.q_valid;
      r_cond_d  = bus.q_valid & ch_res_s;
   end

   // A final advance may coincide with a new start; that start is a reload, not an error.
   always_comb begin
      state_d     = state_q;
      pcc_d       = pcc_q;
      rem_d       = rem_q;
      pred_err_d  = 1'b0;
      start_ok_s  = bus.pred_start && (bus.pred_len != LEN_ZERO);
      last_adv_s  = bus.instr_adv && (rem_q == LEN_ONE);
      len_clamp_s = (bus.pred_len > MAX_LEN_L) ? MAX_LEN_L : bus.pred_len;
      case (state_q)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_d = ST_ACTIVE;
               pcc_d   = bus.pred_cc;
               rem_d   = len_clamp_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (bus.instr_adv) begin
               rem_d = rem_q - LEN_ONE;
            end else begin
               rem_d = rem_q;
            end
            if (last_adv_s) begin
               if (start_ok_s) begin
                  state_d = ST_ACTIVE;
                  pcc_d   = bus.pred_cc;
                  rem_d   = len_clamp_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (bus.pred_start) begin
               pred_err_d = 1'b1;
            end else begin
               pred_err_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rem_d   = LEN_ZERO;
         end
      endcase
   end

   // State update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q    <= 4'd0;
         r_valid_q  <= '0;
         r_cond_q   <= '0;
         state_q    <= ST_IDLE;
         pcc_q      <= 4'd0;
         rem_q      <= LEN_ZERO;
         pred_err_q <= 1'b0;
      end else begin
         flags_q    <= flags_d;
         r_valid_q  <= r_valid_d;
         r_cond_q   <= r_cond_d;
         state_q    <= state_d;
         pcc_q      <= pcc_d;
         rem_q      <= rem_d;
         pred_err_q <= pred_err_d;
      end
   end

   assign bus.flags       = flags_q;
   assign bus.r_valid     = r_valid_q;
   assign bus.r_cond      = r_cond_q;
   assign bus.pred_err    = pred_err_q;
   assign bus.pred_active = (state_q == ST_ACTIVE);
   assign bus.exec_ok     = (state_q != ST_ACTIVE) | fsm_res_s;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench driving a BYPASS=1 and a BYPASS=0 instance with identical stimulus.
module tb_cond_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] flag_in;
   logic       flag_we;
   logic [3:0] flag_mask;
   logic [1:0] q_valid;
   logic [7:0] q_cc;
   logic       pred_start;
   logic [3:0] pred_cc;
   logic [2:0] pred_len;
   logic       instr_adv;
   logic [15:0] sweep;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cond_unit_if #(.NUM_CH(2), .LEN_W(3)) if_b ();
   cond_unit_if #(.NUM_CH(2), .LEN_W(3)) if_n ();

   assign if_b.flag_in    = flag_in;
   assign if_b.flag_we    = flag_we;
   assign if_b.flag_mask  = flag_mask;
   assign if_b.q_valid    = q_valid;
   assign if_b.q_cc       = q_cc;
   assign if_b.pred_start = pred_start;
   assign if_b.pred_cc    = pred_cc;
   assign if_b.pred_len   = pred_len;
   assign if_b.instr_adv  = instr_adv;
   assign if_n.flag_in    = flag_in;
   assign if_n.flag_we    = flag_we;
   assign if_n.flag_mask  = flag_mask;
   assign if_n.q_valid    = q_valid;
   assign if_n.q_cc       = q_cc;
   assign if_n.pred_start = pred_start;
   assign if_n.pred_cc    = pred_cc;
   assign if_n.pred_len   = pred_len;
   assign if_n.instr_adv  = instr_adv;

   cond_unit #(.NUM_CH(2), .MAX_LEN(4), .BYPASS(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   cond_unit #(.NUM_CH(2), .MAX_LEN(4), .BYPASS(0)) u_n (.clk(clk), .rst(rst), .bus(if_n));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_fsm(input string tag, input logic act, input logic ok, input logic err);
      chk({tag, "_act_b"}, 16'(if_b.pred_active), 16'(act));
      chk({tag, "_ok_b"},  16'(if_b.exec_ok),     16'(ok));
      chk({tag, "_err_b"}, 16'(if_b.pred_err),    16'(err));
      chk({tag, "_act_n"}, 16'(if_n.pred_active), 16'(act));
      chk({tag, "_ok_n"},  16'(if_n.exec_ok),     16'(ok));
      chk({tag, "_err_n"}, 16'(if_n.pred_err),    16'(err));
   endtask

   initial begin
      rst = 1'b1; flag_in = 4'd0; flag_we = 1'b0; flag_mask = 4'd0;
      q_valid = 2'b00; q_cc = 8'd0; pred_start = 1'b0; pred_cc = 4'd0;
      pred_len = 3'd0; instr_adv = 1'b0;
      sweep = 16'h66A9;

      // Reset
      tick(); tick();
      chk("rst_flags_b", 16'(if_b.flags), 16'h0);
      chk("rst_flags_n", 16'(if_n.flags), 16'h0);
      chk("rst_rcond_b", 16'(if_b.r_cond), 16'h0);
      chk("rst_rvalid_n", 16'(if_n.r_valid), 16'h0);
      chk_fsm("rst", 1'b0, 1'b1, 1'b0);
      rst = 1'b0;

      // Masked write: only Z lands
      flag_we = 1'b1; flag_in = 4'b1111; flag_mask = 4'b0100;
      tick();
      flag_we = 1'b0;
      chk("mask_flags_b", 16'(if_b.flags), 16'h4);
      chk("mask_flags_n", 16'(if_n.flags), 16'h4);

      // Full code sweep, channel 1 runs the codes in reverse order
      for (int k = 0; k < 16; k++) begin
         q_valid = 2'b11;
         q_cc = {4'(15 - k), 4'(k)};
         tick();
         chk($sformatf("sweep_ch0_cc%0d", k), 16'(if_b.r_cond[0]), 16'(sweep[k]));
         chk($sformatf("sweep_ch1_cc%0d", 15 - k), 16'(if_n.r_cond[1]), 16'(sweep[15 - k]));
         chk("sweep_rvalid", 16'(if_b.r_valid), 16'h3);
      end
      q_valid = 2'b00; q_cc = {CC_AL_T(), CC_AL_T()};
      tick();
      chk("novalid_rcond", 16'(if_b.r_cond), 16'h0);
      chk("novalid_rvalid", 16'(if_n.r_valid), 16'h0);

      // Bypass: clear flags, then write Z and query EQ in the same cycle
      flag_we = 1'b1; flag_mask = 4'b1111; flag_in = 4'b0000;
      tick();
      flag_mask = 4'b0100; flag_in = 4'b0100; q_valid = 2'b01; q_cc = 8'h00;
      tick();
      flag_we = 1'b0;
      chk("byp1_same_cycle", 16'(if_b.r_cond[0]), 16'h1);
      chk("byp0_same_cycle", 16'(if_n.r_cond[0]), 16'h0);
      tick();
      q_valid = 2'b00;
      chk("byp1_next_cycle", 16'(if_b.r_cond[0]), 16'h1);
      chk("byp0_next_cycle", 16'(if_n.r_cond[0]), 16'h1);

      // Predicated block on NE, length 3, with Z set before the third slot
      flag_we = 1'b1; flag_mask = 4'b1111; flag_in = 4'b0000;
      tick();
      flag_we = 1'b0;
      pred_start = 1'b1; pred_cc = 4'd1; pred_len = 3'd3;
      tick();
      pred_start = 1'b0;
      chk_fsm("blk_slot1", 1'b1, 1'b1, 1'b0);
      instr_adv = 1'b1;
      tick();
      chk_fsm("blk_slot2", 1'b1, 1'b1, 1'b0);
      tick();
      instr_adv = 1'b0;
      flag_we = 1'b1; flag_mask = 4'b0100; flag_in = 4'b0100;
      #1;
      chk("blk_bypass_ok_b", 16'(if_b.exec_ok), 16'h0);
      chk("blk_bypass_ok_n", 16'(if_n.exec_ok), 16'h1);
      tick();
      flag_we = 1'b0;
      chk_fsm("blk_slot3", 1'b1, 1'b0, 1'b0);
      instr_adv = 1'b1;
      tick();
      instr_adv = 1'b0;
      chk_fsm("blk_done", 1'b0, 1'b1, 1'b0);

      // Busy error with rem=2, then reload on the final advance
      flag_we = 1'b1; flag_mask = 4'b1111; flag_in = 4'b0000;
      pred_start = 1'b1; pred_cc = 4'd14; pred_len = 3'd3;
      tick();
      flag_we = 1'b0; pred_start = 1'b0; instr_adv = 1'b1;
      tick();
      instr_adv = 1'b0; pred_start = 1'b1; pred_cc = 4'd15; pred_len = 3'd2;
      tick();
      pred_start = 1'b0;
      chk_fsm("busy_err", 1'b1, 1'b1, 1'b1);
      tick();
      chk_fsm("busy_err_clr", 1'b1, 1'b1, 1'b0);
      instr_adv = 1'b1;
      tick();
      chk_fsm("busy_rem1", 1'b1, 1'b1, 1'b0);
      pred_start = 1'b1;
      tick();
      pred_start = 1'b0;
      chk_fsm("reload", 1'b1, 1'b0, 1'b0);
      tick();
      chk_fsm("reload_adv1", 1'b1, 1'b0, 1'b0);
      tick();
      instr_adv = 1'b0;
      chk_fsm("reload_done", 1'b0, 1'b1, 1'b0);

      // Zero length is ignored
      pred_start = 1'b1; pred_cc = 4'd15; pred_len = 3'd0;
      tick();
      pred_start = 1'b0;
      chk_fsm("len0", 1'b0, 1'b1, 1'b0);

      // Length 7 clamps to 4
      pred_start = 1'b1; pred_cc = 4'd14; pred_len = 3'd7;
      tick();
      pred_start = 1'b0; instr_adv = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("clamp_adv%0d_b", k), 16'(if_b.pred_active), 16'(k < 4));
         chk($sformatf("clamp_adv%0d_n", k), 16'(if_n.pred_active), 16'(k < 4));
      end
      instr_adv = 1'b0;

      // Reset mid-block overrides start and flag write
      pred_start = 1'b1; pred_cc = 4'd15; pred_len = 3'd3;
      tick();
      chk_fsm("pre_rst_blk", 1'b1, 1'b0, 1'b0);
      rst = 1'b1; flag_we = 1'b1; flag_mask = 4'b1111; flag_in = 4'b1111;
      tick();
      rst = 1'b0; pred_start = 1'b0; flag_we = 1'b0;
      chk_fsm("mid_rst", 1'b0, 1'b1, 1'b0);
      chk("mid_rst_flags", 16'(if_b.flags), 16'h0);
      tick();
      chk_fsm("post_rst", 1'b0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic [3:0] CC_AL_T();
      return 4'd14;
   endfunction

endmodule

// File: doc/cond_unit.md
# cond_unit

Parametrised successor to the combinational condition tester. Holds the NZCV flag register and evaluates NUM_CH condition-code queries per cycle with registered results. Adds a "never" code and a predicated-block (IT-style) state machine that gates execution of up to MAX_LEN following instructions. Sits between the ALU flag outputs and the issue/branch logic.

## Interface

**Parameters**
- `NUM_CH`, default 2: number of independent condition-query channels.
- `MAX_LEN`, default 4: maximum predicated-block length.
- `BYPASS`, default 1:
  - 1: queries see flags written in the same cycle.
  - 0: queries see registered flags only.
- `LEN_W`, default $clog2(MAX_LEN+1): width of `pred_len`.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flag_in`  in  4  new flags {N,Z,C,V} from the ALU.
- `flag_we`  in  1  flag write enable.
- `flag_mask`  in  4  per-bit write mask; only bits set to 1 are written.
- `q_valid`  in  NUM_CH  per-channel query valid.
- `q_cc`  in  4*NUM_CH  per-channel condition code; channel i uses bits [4i+3:4i].
- `r_valid`  out  NUM_CH  registered copy of `q_valid`.
- `r_cond`  out  NUM_CH  registered condition result.
- `pred_start`  in  1  open a predicated block.
- `pred_cc`  in  4  condition code governing the block.
- `pred_len`  in  LEN_W  number of instructions in the block.
- `instr_adv`  in  1  one instruction retires from the issue slot.
- `pred_active`  out  1  a predicated block is in progress.
- `exec_ok`  out  1  the current issue-slot instruction may execute.
- `pred_err`  out  1  one-cycle pulse: `pred_start` arrived while busy.
- `flags`  out  4  current registered flags.

## Operation

**Condition codes** (n, z, c, v = flag bits [3:0]):

| cc | condition |
|---|---|
| 0 | z |
| 1 | !z |
| 2 | c |
| 3 | !c |
| 4 | n |
| 5 | !n |
| 6 | v |
| 7 | !v |
| 8 | c & !z |
| 9 | !c \| z |
| 10 | n == v |
| 11 | n != v |
| 12 | !z & (n == v) |
| 13 | z \| (n != v) |
| 14 | always (1) |
| 15 | never (0) |

No code leaves the output undefined.

**Flag register**
- When `flag_we` = 1: `flags <= (flags & ~flag_mask) | (flag_in & flag_mask)`.
- Eval flags:
  - `BYPASS` = 1: eval flags are the next-state value (post-mask merge) when `flag_we` = 1, otherwise `flags`.
  - `BYPASS` = 0: eval flags are always `flags`.

**Query channels**
- Each cycle: `r_valid[i] <= q_valid[i]`.
- `r_cond[i] <= q_valid[i] ? eval(q_cc[i], evalflags) : 0`.
- Channels are independent; there is no backpressure.

**Predication FSM** (states IDLE, ACTIVE; registers `pcc_q`, `rem_q`)
- **IDLE:**
  - `pred_start` with `pred_len` ≥ 1 → ACTIVE.
  - `pcc_q <= pred_cc`.
  - `rem_q <= min(pred_len, MAX_LEN)`.
  - `pred_len` = 0 is ignored; no error is raised.
- **ACTIVE:**
  - `instr_adv` decrements `rem_q`.
  - When `instr_adv` arrives with `rem_q` = 1 → IDLE.
- **`pred_start` while ACTIVE:**
  - If it coincides with the final `instr_adv` (`rem_q` = 1), it is accepted: the FSM reloads and stays ACTIVE.
  - Otherwise it is ignored and `pred_err` pulses for one cycle.
- **Outputs:**
  - `pred_active` = (state == ACTIVE).
  - `exec_ok` = !`pred_active` | eval(`pcc_q`, evalflags). This path is combinational from registered state, and honours `BYPASS`.
  - Flags are re-evaluated for every instruction in the block, so flag writes inside the block affect later slots.

## Timing

- **Reset values:**
  - `flags` = 0, `r_valid` = 0, `r_cond` = 0.
  - state = IDLE, `rem_q` = 0, `pcc_q` = 0.
  - `pred_active` = 0, `exec_ok` = 1, `pred_err` = 0.
- **Reset priority:** `rst` overrides every input in the same cycle. A block in progress is abandoned; there is no pending error.
- **Query latency:** 1 cycle from `q_valid` to `r_valid` / `r_cond`.
- **Flag write visibility:**
  - `BYPASS` = 0: a flag write is visible to queries issued 1 cycle later.
  - `BYPASS` = 1: a flag write is visible to queries in the same cycle.
- **FSM timing:**
  - `pred_start` in cycle t → `pred_active` = 1 from cycle t+1.
  - The first gated instruction is the one presented at t+1.
  - `instr_adv` in cycle t+1 with `pred_len` = 1 → `pred_active` = 0 at t+2.
- **`instr_adv` in IDLE:** no effect.

## Structure

- **Package `cond_pkg`:**
  - Localparams for cc values 0–15 (`CC_EQ` … `CC_NV`).
  - Flag bit indices `FLG_N` = 3, `FLG_Z` = 2, `FLG_C` = 1, `FLG_V` = 0.
  - A function `cond_eval(cc, flags)`.
- **Sub-module `cond_eval`:** combinational wrapper around the package function. It is instantiated NUM_CH + 1 times: once per channel, plus once for the FSM.
- **Top level** holds the flag register, the output registers and the FSM.

## Test plan

- **Reset:** `rst` = 1 for 2 cycles → `flags` = 0, `exec_ok` = 1, `pred_active` = 0, `r_cond` = 0.
- **Masked write and full code sweep:**
  - Write `flag_in` = 4'b1111 with `flag_mask` = 4'b0100 → `flags` = 4'b0100.
  - Sweep cc 0–15 on channel 0 → `r_cond` = 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0.
- **Bypass:**
  - `BYPASS` = 1: write Z = 1 and query cc = 0 in the same cycle → `r_cond` = 1 next cycle.
  - `BYPASS` = 0: same stimulus → `r_cond` = 0.
- **Predicated block:**
  - Start with `pred_cc` = 1 (NE), `pred_len` = 3, Z = 0.
  - Three `instr_adv` → `exec_ok` = 1, 1, then Z is set → 0.
  - `pred_active` drops after the third advance.
- **Busy error:**
  - `pred_start` mid-block with `rem_q` = 2 → `pred_err` pulses for 1 cycle and `rem_q` is unchanged.
  - `pred_start` coinciding with the final `instr_adv` → reloads, no error.
- **Edge cases:**
  - `pred_len` = 0 → stays IDLE.
  - `pred_len` = 7 with `MAX_LEN` = 4 → exactly 4 advances close the block.
  - `rst` mid-block → IDLE next cycle.
